// File: rtl/icache_pkg.sv
// Shared types, geometry and address-split helpers for the direct-mapped
// instruction cache controller.
`ifndef ICACHE_INDEX
`define ICACHE_INDEX 4
`endif
`ifndef ICACHE_SIZE
`define ICACHE_SIZE (2 ** `ICACHE_INDEX)
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif

package icache_pkg;

    localparam int unsigned PKG_ADDR_W      = 32;
    localparam int unsigned PKG_INDEX_W     = `ICACHE_INDEX;
    localparam int unsigned PKG_WORD_W      = `DRAM_WORD_SIZE;
    localparam int unsigned PKG_BLOCK_WORDS = `DRAM_BLOCK_SIZE;
    localparam int unsigned NUM_LINES       = `ICACHE_SIZE;

    // Block holds at least two words, so the word-select field is never empty.
    localparam int unsigned WSEL_W = $clog2(PKG_BLOCK_WORDS);
    localparam int unsigned OFF_W  = 2 + WSEL_W;
    localparam int unsigned TAG_W  = PKG_ADDR_W - PKG_INDEX_W - OFF_W;

    typedef enum logic {
        IDLE,
        MISS
    } state_e;

    function automatic logic [PKG_INDEX_W-1:0] get_index(input logic [PKG_ADDR_W-1:0] addr);
        return addr[OFF_W +: PKG_INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] get_tag(input logic [PKG_ADDR_W-1:0] addr);
        return addr[PKG_ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [WSEL_W-1:0] get_word(input logic [PKG_ADDR_W-1:0] addr);
        return addr[2 +: WSEL_W];
    endfunction

    function automatic logic [PKG_ADDR_W-1:0] block_align(input logic [PKG_ADDR_W-1:0] addr);
        return {addr[PKG_ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_tag_store.sv
// Tag array plus valid vector: one combinational read port, one write port,
// and a single-cycle invalidate-all.
module icache_tag_store
    import icache_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [PKG_INDEX_W-1:0] rd_index_i,
    output logic [TAG_W-1:0]       rd_tag_o,
    output logic                   rd_valid_o,
    input  logic                   wr_en_i,
    input  logic [PKG_INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]       wr_tag_i,
    input  logic                   flush_all_i
);

    logic [TAG_W-1:0]     tag_mem_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;

    assign rd_tag_o   = tag_mem_q[rd_index_i];
    assign rd_valid_o = valid_q[rd_index_i];

    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_index_i] = 1'b1;
        end
        if (flush_all_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tags are only meaningful behind a set valid bit, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_mem_q[wr_index_i] <= wr_tag_i;
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: zero-latency hit check, whole-block
// refill from DRAM on a miss, then a replayed lookup.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W      = PKG_ADDR_W,
    parameter int unsigned INDEX_W     = PKG_INDEX_W,
    parameter int unsigned WORD_W      = PKG_WORD_W,
    parameter int unsigned BLOCK_WORDS = PKG_BLOCK_WORDS,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic [WORD_W-1:0]  cpu_inst,
    output logic               cpu_valid,
    output logic               cpu_stall,
    input  logic               flush,
    output logic               dram_req,
    output logic [ADDR_W-1:0]  dram_addr,
    input  logic               dram_ack,
    input  logic [WORD_W-1:0]  dram_data [BLOCK_WORDS],
    output logic               sram_we,
    output logic [INDEX_W-1:0] sram_index,
    output logic [WORD_W-1:0]  sram_wdata [BLOCK_WORDS],
    input  logic [WORD_W-1:0]  sram_rdata [BLOCK_WORDS],
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  miss_addr_q, miss_addr_d;
    logic               replay_q, replay_d;
    logic               flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic               hit;
    logic               fill_we;
    logic               flush_all;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    icache_tag_store u_tag_store (
        .clk_i       (clock),
        .rst_i       (reset),
        .rd_index_i  (get_index(cpu_addr)),
        .rd_tag_o    (rd_tag),
        .rd_valid_o  (rd_valid),
        .wr_en_i     (fill_we),
        .wr_index_i  (get_index(miss_addr_q)),
        .wr_tag_i    (get_tag(miss_addr_q)),
        .flush_all_i (flush_all)
    );

    assign hit = (state_q == IDLE) & cpu_req & rd_valid & (rd_tag == get_tag(cpu_addr));

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        replay_d     = replay_q;
        flush_pend_d = flush_pend_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        fill_we      = 1'b0;
        flush_all    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A flush deferred from MISS lands on the replay edge, after its lookup.
                flush_all    = flush | flush_pend_q;
                flush_pend_d = 1'b0;
                if (cpu_req) begin
                    replay_d = 1'b0;
                    if (hit) begin
                        if (!replay_q) begin
                            hit_cnt_d = sat_inc(hit_cnt_q);
                        end
                    end else begin
                        miss_addr_d = block_align(cpu_addr);
                        miss_cnt_d  = sat_inc(miss_cnt_q);
                        state_d     = MISS;
                    end
                end
            end
            MISS: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (dram_ack) begin
                    fill_we  = 1'b1;
                    replay_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            replay_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            replay_q     <= replay_d;
            flush_pend_q <= flush_pend_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // CPU-facing outputs are forced quiet while reset is held.
    assign cpu_valid  = ~reset & hit;
    assign cpu_stall  = ~reset & ((state_q == MISS) | (cpu_req & ~hit));
    assign cpu_inst   = hit ? sram_rdata[get_word(cpu_addr)] : '0;

    assign dram_req   = (state_q == MISS);
    assign dram_addr  = dram_req ? miss_addr_q : '0;

    assign sram_we    = fill_we;
    assign sram_index = (state_q == IDLE) ? get_index(cpu_addr) : get_index(miss_addr_q);
    assign sram_wdata = dram_data;

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Controller for the direct-mapped instruction cache data SRAM.
- Owns the tag/valid store and performs the hit check on each CPU fetch.
- On a hit, returns the word combinationally from the SRAM read port. On a miss, stalls the CPU, fetches the whole block from DRAM, writes it into the SRAM, then replays the lookup.
- Sits between the fetch stage, the cache data SRAM and the DRAM block interface.

Parameters:
- ADDR_W, 32: byte-address width.
- INDEX_W, `ICACHE_INDEX: cache index bits. Number of lines = `ICACHE_SIZE = 2**INDEX_W.
- WORD_W, `DRAM_WORD_SIZE: instruction/word width in bits.
- BLOCK_WORDS, `DRAM_BLOCK_SIZE: words per line (power of 2).
- CNT_W, 16: width of the hit and miss counters.

Ports:
- clock input 1: single clock, all state updates on posedge.
- reset input 1: asynchronous, active-high.
- cpu_req input 1: fetch request.
- cpu_addr input ADDR_W: byte address. Held stable by the CPU while cpu_stall=1.
- cpu_inst output WORD_W: fetched instruction, valid when cpu_valid=1.
- cpu_valid output 1: cpu_inst valid this cycle.
- cpu_stall output 1: access not served this cycle.
- flush input 1: single-cycle pulse; invalidate all lines.
- dram_req output 1: block read request. Level signal, held until dram_ack.
- dram_addr output ADDR_W: block-aligned miss address.
- dram_ack input 1: single-cycle pulse; dram_data valid in the same cycle.
- dram_data input WORD_W x BLOCK_WORDS: unpacked fill block.
- sram_we output 1: write enable to the data SRAM.
- sram_index output INDEX_W: SRAM index.
- sram_wdata output WORD_W x BLOCK_WORDS: SRAM write block, driven directly from dram_data.
- sram_rdata input WORD_W x BLOCK_WORDS: SRAM combinational read block.
- hit_count output CNT_W: saturating count of hits.
- miss_count output CNT_W: saturating count of misses.

Behaviour:
- Address split:
  - byte offset = addr[1:0], ignored.
  - word select = addr[OFF_W-1:2], where OFF_W = 2 + log2(BLOCK_WORDS).
  - index = addr[OFF_W+INDEX_W-1:OFF_W].
  - tag = remaining upper bits, TAG_W = ADDR_W - INDEX_W - OFF_W.
- Reset (asynchronous, immediate):
  - state=IDLE; all valid bits 0.
  - dram_req=0, sram_we=0, counters 0, flush_pend=0, replay=0.
  - Tags need no reset.
- Outputs during reset: cpu_valid=0, cpu_stall=0, dram_addr=0.
- sram_index:
  - In IDLE: index of cpu_addr.
  - In MISS: index of the latched miss address.
- State IDLE:
  - hit = cpu_req & valid[idx] & (tag_mem[idx]==tag).
  - On hit: cpu_valid=1, cpu_stall=0, cpu_inst = sram_rdata[word]. Zero-cycle latency.
  - hit_count increments on a hit unless replay=1. replay clears on any cycle with cpu_req=1.
  - On cpu_req & !hit: cpu_stall=1, cpu_valid=0. Latch the block-aligned address into miss_addr, increment miss_count, go to MISS.
  - With cpu_req=0: cpu_valid=0, cpu_stall=0.
- State MISS:
  - dram_req=1, dram_addr=miss_addr, cpu_stall=1, cpu_valid=0.
  - On dram_ack: sram_we=1 for that cycle. In the same edge, write tag_mem/valid[idx] from miss_addr, set replay=1, go to IDLE.
  - The next IDLE cycle re-looks-up and hits. Miss penalty = DRAM latency + 1 cycle.
- Flush:
  - In IDLE: clear all valid bits at the next edge. A lookup in the same cycle uses the pre-flush valid bits.
  - In MISS: set flush_pend. The fill completes, the replayed access is served, then all valid bits clear on the first IDLE edge after the replay hit.
- Simultaneous events:
  - cpu_req deasserted during MISS: the fill still completes; no response.
  - dram_ack outside MISS is ignored: no sram_we, no state change.
  - Reset during MISS: dram_req drops immediately. The DRAM side must discard the abandoned request.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Package icache_pkg holds:
  - state enum {IDLE, MISS};
  - localparams OFF_W and TAG_W;
  - functions get_index, get_tag, get_word, block_align.
- Sub-module icache_tag_store holds:
  - tag array and valid vector;
  - combinational read port and one write port;
  - single-cycle flush_all input;
  - asynchronous reset of the valid bits.

Test Plan:
Bench config: ICACHE_SIZE=16, INDEX_W=4, BLOCK_WORDS=4, WORD_W=32, so OFF_W=4.
1. Cold miss: after reset, cpu_req with addr 0x0000_0104. Required response:
   - cpu_stall=1 and miss_count=1.
   - Next cycle: dram_req=1, dram_addr=0x100.
   - Ack after 3 cycles with {A0,A1,A2,A3}: sram_we pulses with index 0.
   - Following cycle: cpu_valid=1, cpu_inst=A1, hit_count=0.
2. Hit: addr 0x108 -> same cycle cpu_valid=1, cpu_inst=A2, cpu_stall=0, hit_count=1, dram_req stays 0.
3. Conflict: addr 0x1100 (index 0, tag 0x11) -> miss and refill with {B0..B3}, returns B0. Then 0x100 -> miss again; miss_count=3.
4. Flush pulse while dram_req=1 for 0x200:
   - The fill completes and the replay returns the word.
   - Next cycle, 0x200 misses.
   - A valid 0x100 line is also invalidated.
5. Reset asserted mid-cycle while in MISS:
   - dram_req=0 and counters 0 without waiting for a clock edge.
   - After release, 0x104 misses.
6. Stray dram_ack in IDLE with no miss -> sram_we=0, no state change, counters unchanged.
